// File: rtl/spi_slave_pkg.sv
// Shared constants and FSM state encoding for the SPI responder register bank.
package spi_slave_pkg;

  localparam int CMD_W    = 4;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [CMD_W-1:0] CMD_WRITE = 4'b1011;
  localparam logic [CMD_W-1:0] CMD_READ  = 4'b1010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_IGNORE = 3'd4
  } state_e;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-stage synchroniser for the SPI pins plus edge detection of synced SCK and CS.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic cs_n,
  input  logic sdi,
  output logic sdi_s,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_rise,
  output logic cs_fall
);

  logic [SYNC_STAGES-1:0] sck_sync_reg;
  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] sdi_sync_reg;
  logic                   sck_d_reg;
  logic                   cs_d_reg;
  logic                   sck_s;
  logic                   cs_s;

  // CS idles high so its chain resets to 1; a spurious CS edge never appears after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_reg <= '0;
      cs_sync_reg  <= '1;
      sdi_sync_reg <= '0;
      sck_d_reg    <= 1'b0;
      cs_d_reg     <= 1'b1;
    end else begin
      sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
      cs_sync_reg  <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
      sdi_sync_reg <= {sdi_sync_reg[SYNC_STAGES-2:0], sdi};
      sck_d_reg    <= sck_s;
      cs_d_reg     <= cs_s;
    end
  end

  assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
  assign cs_s     = cs_sync_reg[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_reg[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d_reg;
  assign sck_fall = ~sck_s & sck_d_reg;
  assign cs_rise  = cs_s & ~cs_d_reg;
  assign cs_fall  = ~cs_s & cs_d_reg;

endmodule

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder with a 16-entry register bank, all logic in the pclk domain.
// Define SPI_SLAVE_READBACK_EN to enable READ frames (SDO shift-out); otherwise READ is an invalid command.
module spi_slave_regfile
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              pclk_i,
  input  logic              rst_n_i,
  input  logic              spi_clk_i,
  input  logic              spi_cs_n_i,
  input  logic              spi_sdi_i,
  output logic              spi_sdo_o,
  output logic              spi_sdo_oe_o,
  input  logic [ADDR_W-1:0] reg_raddr_i,
  output logic [DATA_W-1:0] reg_rdata_o,
  output logic              wr_strobe_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              frame_err_o
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_NIB  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);

  logic sdi_s, sck_rise, sck_fall, cs_rise, cs_fall;

  spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (pclk_i),
    .rst_n    (rst_n_i),
    .sck      (spi_clk_i),
    .cs_n     (spi_cs_n_i),
    .sdi      (spi_sdi_i),
    .sdi_s    (sdi_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  state_e            state_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [CMD_W-1:0]  cmd_sh_reg;
  logic [ADDR_W-1:0] addr_sh_reg;
  logic [DATA_W-1:0] data_sh_reg;
  logic              is_read_reg;
  logic              bad_cmd_reg;
  logic [DATA_W-1:0] bank [NUM_REGS];

  logic [CMD_W-1:0]  cmd_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] data_next;
  logic              cmd_rd;
  logic              cmd_ok;
  logic              commit;

  assign cmd_next  = {cmd_sh_reg[CMD_W-2:0], sdi_s};
  assign addr_next = {addr_sh_reg[ADDR_W-2:0], sdi_s};
  assign data_next = {data_sh_reg[DATA_W-2:0], sdi_s};

`ifdef SPI_SLAVE_READBACK_EN
  assign cmd_rd = (cmd_next == CMD_READ);
`else
  assign cmd_rd = 1'b0;
`endif
  assign cmd_ok = (cmd_next == CMD_WRITE) || cmd_rd;

  assign commit = !cs_rise && (state_reg == ST_DATA) && sck_rise &&
                  (bit_cnt_reg == LAST_DATA) && !is_read_reg;

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg   <= ST_IDLE;
      bit_cnt_reg <= '0;
      cmd_sh_reg  <= '0;
      addr_sh_reg <= '0;
      data_sh_reg <= '0;
      is_read_reg <= 1'b0;
      bad_cmd_reg <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o   <= '0;
      wr_data_o   <= '0;
      frame_err_o <= 1'b0;
    end else begin
      wr_strobe_o <= 1'b0;
      frame_err_o <= 1'b0;
      if (cs_rise) begin
        // A frame that ended before its data completed, or that carried a bad command, is flagged.
        frame_err_o <= (state_reg inside {ST_CMD, ST_ADDR, ST_DATA}) ||
                       ((state_reg == ST_IGNORE) && bad_cmd_reg);
        state_reg   <= ST_IDLE;
        bit_cnt_reg <= '0;
        is_read_reg <= 1'b0;
        bad_cmd_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (cs_fall) begin
              state_reg   <= ST_CMD;
              bit_cnt_reg <= '0;
            end
          end
          ST_CMD: begin
            if (sck_rise) begin
              cmd_sh_reg <= cmd_next;
              if (bit_cnt_reg == LAST_NIB) begin
                bit_cnt_reg <= '0;
                if (cmd_ok) begin
                  state_reg   <= ST_ADDR;
                  is_read_reg <= cmd_rd;
                end else begin
                  state_reg   <= ST_IGNORE;
                  bad_cmd_reg <= 1'b1;
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
              end
            end
          end
          ST_ADDR: begin
            if (sck_rise) begin
              addr_sh_reg <= addr_next;
              if (bit_cnt_reg == LAST_NIB) begin
                bit_cnt_reg <= '0;
                state_reg   <= ST_DATA;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
              end
            end
          end
          ST_DATA: begin
            if (sck_rise) begin
              data_sh_reg <= data_next;
              if (bit_cnt_reg == LAST_DATA) begin
                bit_cnt_reg <= '0;
                state_reg   <= ST_IGNORE;
                if (!is_read_reg) begin
                  wr_strobe_o <= 1'b1;
                  wr_addr_o   <= addr_sh_reg;
                  wr_data_o   <= data_next;
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
              end
            end
          end
          ST_IGNORE: ;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bank
    always_ff @(posedge pclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        bank[gi] <= '0;
      end else if (commit && (addr_sh_reg == ADDR_W'(gi))) begin
        bank[gi] <= data_next;
      end
    end
  end

  assign reg_rdata_o = bank[reg_raddr_i];

`ifdef SPI_SLAVE_READBACK_EN
  logic [DATA_W-1:0] rd_sh_reg;
  logic              oe_reg;
  logic              rd_load;

  assign rd_load = !cs_rise && (state_reg == ST_ADDR) && sck_rise &&
                   (bit_cnt_reg == LAST_NIB) && is_read_reg;

  // The fall right after the last address bit must not shift: the MSB is still owed to the master.
  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_sh_reg <= '0;
      oe_reg    <= 1'b0;
    end else if (cs_rise) begin
      rd_sh_reg <= '0;
      oe_reg    <= 1'b0;
    end else if (rd_load) begin
      rd_sh_reg <= bank[addr_next];
      oe_reg    <= 1'b1;
    end else if (oe_reg && (state_reg == ST_DATA)) begin
      if (sck_rise && (bit_cnt_reg == LAST_DATA)) begin
        rd_sh_reg <= '0;
        oe_reg    <= 1'b0;
      end else if (sck_fall && (bit_cnt_reg != '0)) begin
        rd_sh_reg <= {rd_sh_reg[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign spi_sdo_o    = oe_reg & rd_sh_reg[DATA_W-1];
  assign spi_sdo_oe_o = oe_reg;
`else
  logic unused_sck_fall;
  assign unused_sck_fall = sck_fall;
  assign spi_sdo_o       = 1'b0;
  assign spi_sdo_oe_o    = 1'b0;
`endif

endmodule

// File: doc/spi_slave_regfile.md
# spi_slave_regfile

SPI responder with a small register bank: the device-side counterpart of the APB SPI master. Decodes frames of 4-bit command, 4-bit address and DATA_W data bits, MSB first, SPI mode 0. Write frames update an internal register; read frames shift a register out on SDO. Runs entirely in the pclk domain; SPI inputs are oversampled through synchronisers.

## Interface
- DATA_W, 16, data field width in bits; also register width.
- SYNC_STAGES, 2, flip-flop stages on spi_clk_i, spi_cs_n_i and spi_sdi_i (≥2).
- pclk_i  in  1  system clock. One clock only.
- rst_n_i  in  1  asynchronous, active-low reset.
- spi_clk_i  in  1  SPI clock from the master; idles low.
- spi_cs_n_i  in  1  chip select, active low.
- spi_sdi_i  in  1  master-to-slave data.
- spi_sdo_o  out  1  slave-to-master data; 0 when not driving read data.
- spi_sdo_oe_o  out  1  high while a read data field is in progress.
- reg_raddr_i  in  4  local read address into the register bank.
- reg_rdata_o  out  DATA_W  combinational read of reg[reg_raddr_i].
- wr_strobe_o  out  1  one-pclk pulse when a write frame commits.
- wr_addr_o  out  4  address of the committed write; valid with wr_strobe_o.
- wr_data_o  out  DATA_W  data of the committed write; valid with wr_strobe_o.
- frame_err_o  out  1  one-pclk pulse on an aborted or invalid frame.

## Operation
- Bank: 16 registers × DATA_W, reset to 0.
- Sync: spi_clk_i, spi_cs_n_i and spi_sdi_i pass through SYNC_STAGES flops; rise/fall of the synced clock is detected against a one-cycle-delayed copy.
- Sampling: SDI sampled on synced SCK rise. SDO updated on synced SCK fall.
- FSM: IDLE, CMD, ADDR, DATA, IGNORE.
- IDLE: synced CS falls → CMD, bit counter = 0.
- CMD: shift 4 bits. After the 4th: 4'b1011 (WRITE) or 4'b1010 (READ) → ADDR; any other value → IGNORE.
- ADDR: shift 4 bits. After the 4th on READ: load the read shift register with reg[addr] in the same pclk cycle and assert spi_sdo_oe_o. Then → DATA.
- DATA, WRITE: shift DATA_W bits. After the last bit: reg[addr] ← data, pulse wr_strobe_o with wr_addr_o/wr_data_o, → IGNORE.
- DATA, READ: drive the MSB on SDO immediately; shift left on each SCK fall. After DATA_W rises → IGNORE, drop oe, SDO = 0.
- IGNORE: discard all further bits until CS rises.
- CS rise in any state → IDLE, and counters cleared.
- frame_err_o: pulses on a CS rise that occurs either in CMD/ADDR/DATA (short frame) or in IGNORE reached through an invalid command. A short WRITE frame never modifies the bank.
- Simultaneous events: a local read of the address being written in the same cycle returns the old value. Commit has priority over nothing else; the bank has a single write source.

## Timing
- Reset: all outputs 0; FSM IDLE; bank 0; sync flops 1 for CS, 0 for SCK and SDI.
- Input latency: SYNC_STAGES+1 pclk from pin edge to action.
- Constraint: SCK high and low phases each ≥ SYNC_STAGES+2 pclk. The APB master's divider 4 (8 pclk/period) satisfies this.
- Write commit: wr_strobe_o asserts SYNC_STAGES+1 pclk after the SCK rise carrying the last data bit.
- Read: the first SDO bit is valid before the next SCK rise after the last address bit.
- Reset mid-frame: immediate return to IDLE; no commit; no error pulse.

## Configuration
- SPI_SLAVE_READBACK_EN defined: READ command supported as above.
- SPI_SLAVE_READBACK_EN undefined: the read shift register and oe logic are removed. 4'b1010 is treated as an invalid command (→ IGNORE, frame_err_o at CS rise). spi_sdo_o and spi_sdo_oe_o are tied 0.

## Structure
- Package spi_slave_pkg contains: CMD_W=4, ADDR_W=4, CMD_WRITE=4'b1011, CMD_READ=4'b1010, and the FSM state enum.
- Sub-module spi_slave_sync contains the parameterised synchroniser and SCK rise/fall detector; it is instantiated once.

## Test plan
- Write frame cmd 1011, addr 1011, data 0xA001 at divider 4 → wr_strobe_o is one pulse with wr_addr_o=0xB and wr_data_o=0xA001; reg_rdata_o at raddr 0xB = 0xA001.
- After that write, read frame cmd 1010, addr 1011 → SDO shifts 1010_0000_0000_0001 MSB first; oe is high for exactly 16 SCK periods.
- Write frame to addr 3 with CS raised after 10 SCK rises → frame_err_o pulses once; reg[3] stays 0; no wr_strobe_o.
- Command 0101, then 24 clocks → no strobe, SDO stays 0, frame_err_o is pulsed at CS rise; the next valid write succeeds.
- Write frame with 20 data clocks → commit of the first 16 bits only; extra bits are ignored; no error.
- rst_n_i is asserted during DATA of a write → bank is unchanged (0). A fresh frame after release works normally.
